// File: rtl/seg_pkg.sv
// Shared constants for the 8-digit 7-segment scan controller.
// Segment patterns are active-high, bit order g..a.
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [7:0] anode_sel(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to 7-segment decoder.
// Output is active-high, bit order g..a; A-F render as A,b,C,d,E,F.
import seg_pkg::*;

module hex_to_7seg (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Full 16-entry lookup on the selected nibble.
    always_comb begin
        seg_o = SEG_0;
        unique case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Contents are shadowed and only reload at the frame wrap, so digits never tear.
import seg_pkg::*;

module seg_scan_ctrl #(
    parameter int DIV  = 100000,
    parameter int DEAD = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp,
    input  logic        blank,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic        frame_done,
    output logic [7:0]  anode,
    output logic [7:0]  cathode
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);
    localparam logic [2:0]    IDX_MAX = 3'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          tick;
    logic          boundary;

    logic [31:0]   shadow_digits_q, shadow_digits_d;
    logic [7:0]    shadow_en_q, shadow_en_d;
    logic [7:0]    shadow_dp_q, shadow_dp_d;

    logic          upd_ack_q, upd_ack_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    anode_q, anode_d;
    logic [7:0]    cathode_q, cathode_d;

    logic [3:0]    nibble;
    logic [6:0]    seg;
    logic          in_dead;
    logic          lit;

    assign tick     = (cnt_q == CNT_MAX);
    assign boundary = tick && (idx_q == IDX_MAX);

    // Prescaler wraps every DIV cycles; digit index advances on each wrap.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Shadow reload and handshake pulses, only at the frame wrap.
    always_comb begin
        shadow_digits_d = shadow_digits_q;
        shadow_en_d     = shadow_en_q;
        shadow_dp_d     = shadow_dp_q;
        frame_done_d    = boundary;
        upd_ack_d       = boundary && upd_req;
        if (boundary && upd_req) begin
            shadow_digits_d = digits;
            shadow_en_d     = digit_en;
            shadow_dp_d     = dp;
        end
    end

    assign nibble = shadow_digits_q[{idx_q, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .nibble_i (nibble),
        .seg_o    (seg)
    );

    // Drive the current slot unless blanked, disabled or in the dead window.
    always_comb begin
        in_dead   = (cnt_q < DEAD_C);
        lit       = !blank && shadow_en_q[idx_q] && !in_dead;
        anode_d   = SEG_OFF;
        cathode_d = SEG_OFF;
        if (lit) begin
            anode_d   = anode_sel(idx_q);
            cathode_d = {~shadow_dp_q[idx_q], ~seg};
        end
    end

    // Scan counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Shadow display contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_digits_q <= '0;
            shadow_en_q     <= '0;
            shadow_dp_q     <= '0;
        end else begin
            shadow_digits_q <= shadow_digits_d;
            shadow_en_q     <= shadow_en_d;
            shadow_dp_q     <= shadow_dp_d;
        end
    end

    // Registered outputs, one cycle behind the scan counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
            anode_q      <= SEG_OFF;
            cathode_q    <= SEG_OFF;
        end else begin
            upd_ack_q    <= upd_ack_d;
            frame_done_q <= frame_done_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
        end
    end

    assign upd_ack    = upd_ack_q;
    assign frame_done = frame_done_q;
    assign anode      = anode_q;
    assign cathode    = cathode_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit common-anode 7-segment display. It shares the single cathode bus across all eight anodes and decodes eight hex nibbles into segment patterns. Display contents are held in shadow registers that load only at a frame boundary, so digits never tear. It replaces the fixed single-digit anode drive. Its inputs are fed by the pattern selector, generation counter and similar sources.

Parameters:
DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz per digit); legal range DIV >= 2.
DEAD, 1000, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 <= DEAD < DIV.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
digits  input  32  eight hex nibbles; digits[4k+3:4k] drives digit k
digit_en  input  8  per-digit enable; 0 blanks that digit
dp  input  8  per-digit decimal point, 1 = lit
blank  input  1  forces all anodes off, live (not shadowed)
upd_req  input  1  level request to load the shadow registers
upd_ack  output  1  one-cycle pulse: shadow registers loaded
frame_done  output  1  one-cycle pulse at each frame wrap
anode  output  8  active-low; anode[k] selects digit k
cathode  output  8  active-low; [6:0] = segments g..a, [7] = DP

Behaviour:
- Reset (async, active-high) forces these values immediately, including mid-scan:
  - anode=8'hFF, cathode=8'hFF
  - upd_ack=0, frame_done=0
  - cnt=0, idx=0
  - shadow digits/en/dp = 0
- Prescaler cnt counts 0..DIV-1 and wraps. tick = (cnt==DIV-1).
- idx counts 0..7 and advances on tick. On tick with idx==7 it wraps to 0; that cycle is the frame boundary.
- Frame boundary (clock edge where tick && idx==7):
  - frame_done <= 1 for exactly one cycle.
  - If upd_req==1 that cycle: shadow_digits<=digits, shadow_en<=digit_en, shadow_dp<=dp, and upd_ack <= 1 for one cycle.
  - upd_req is sampled only in the boundary cycle, so a request rising in that same cycle is captured.
- Handshake:
  - Requester holds upd_req until it sees upd_ack, then deasserts.
  - If upd_req is still high at the next boundary, the shadow reloads and upd_ack pulses again. This is legal.
  - digits/dp/digit_en are don't-care outside the boundary cycle.
- Output generation, registered with one-cycle latency from (cnt, idx):
  - If blank, or shadow_en[idx]==0, or cnt < DEAD: anode=8'hFF, cathode=8'hFF.
  - Otherwise: anode = ~(8'b1 << idx), cathode[6:0] = ~seg(shadow_digits nibble idx), cathode[7] = ~shadow_dp[idx].
- seg() is a full hex decode; A-F display as A,b,C,d,E,F.
- Exactly one anode is low at any time, or none. Never two.
- Disabled digits still consume their slot, so the scan period is fixed at 8*DIV.
- After reset release, digit 0 is the first slot. All digits stay dark, because shadow_en is 0, until the first upd_ack.

Decomposition:
- Shared package seg_pkg holds:
  - 7-bit segment constants for 0-F, active-high, g..a
  - SEG_OFF = 8'hFF
  - NUM_DIGITS = 8
- One combinational sub-module, hex_to_7seg (4-bit in, 7-bit active-high out), instantiated once on the muxed nibble.
- Prescaler, index counter, shadow registers and output registers are kept inline in seg_scan_ctrl.

Test Plan:
1. Reset/idle, DIV=4 DEAD=1, no upd_req: anode=cathode=8'hFF throughout. frame_done pulses every 32 cycles, first pulse 32 cycles after reset release.
2. Load and scan: digits=32'h7654_3210, digit_en=8'hFF, dp=8'h01, upd_req held high.
   - upd_ack pulses once at the first boundary.
   - Next frame: anode steps FE,FD,FB,...,7F, each low for 3 of 4 cycles with FF in the dead cycle.
   - Cathodes are ~seg(0..7); cathode[7]=0 only while anode=FE.
3. Shadowing: after the load, change digits to 32'hFFFF_FFFF without upd_req. Displayed values stay 0..7 for several frames. Raise upd_req and all digits show F after the next upd_ack.
4. Boundary race: assert upd_req exactly in the boundary cycle. upd_ack fires that boundary, not the next one.
5. Enables and blank: digit_en=8'b1010_1010 gives anode FF during the even slots. Asserting blank mid-slot gives anode=FF one cycle later; deasserting it resumes the correct idx with no change to scan timing.
6. Reset mid-scan (idx=5, cnt=2): outputs go FF asynchronously. After release, scanning restarts at digit 0 and stays dark until a new upd_ack.
